// File: rtl/wisc_pkg.sv
// Shared types and encodings for the WISC pipeline hazard/forwarding control.
package wisc_pkg;

    localparam int unsigned REG_W = 3;

    localparam logic [1:0] RS_REG = 2'b00;
    localparam logic [1:0] RS_WB  = 2'b01;
    localparam logic [1:0] RS_MEM = 2'b10;

    localparam logic [1:0] RT_MEM = 2'b00;
    localparam logic [1:0] RT_WB  = 2'b01;
    localparam logic [1:0] RT_REG = 2'b10;
    localparam logic [1:0] RT_IMM = 2'b11;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } hz_state_e;

    typedef struct packed {
        logic             v;
        logic [REG_W-1:0] rd;
        logic             ld;
    } sb_slot_t;

endpackage

// File: rtl/wisc_fwd_sel.sv
// Combinational forwarding select for one ALU source; is_rt picks the Rt encoding.
module wisc_fwd_sel
    import wisc_pkg::*;
(
    input  logic [REG_W-1:0] src,
    input  logic             used,
    input  logic             use_imm,
    input  logic             is_store,
    input  logic             is_rt,
    input  logic             ex_v,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             mem_v,
    input  logic [REG_W-1:0] mem_rd,
    output logic [1:0]       sel_c
);

    logic [1:0] reg_enc;
    logic [1:0] ex_enc;

    always_comb begin
        reg_enc = is_rt ? RT_REG : RS_REG;
        ex_enc  = is_rt ? RT_MEM : RS_MEM;
        sel_c   = reg_enc;
        // Store data always needs Rt; EX substitutes the immediate for the address itself.
        if (is_rt && use_imm && !is_store) begin
            sel_c = RT_IMM;
        end else if (used) begin
            if (ex_v && (ex_rd == src)) begin
                sel_c = ex_enc;
            end else if (mem_v && (mem_rd == src)) begin
                sel_c = is_rt ? RT_WB : RS_WB;
            end
        end
    end

endmodule

// File: rtl/wisc_hazard_ctrl.sv
// Decode-stage hazard controller: destination scoreboard, forwarding selects,
// load-use stall, EX-resolved flush and halt drain sequencing.
module wisc_hazard_ctrl
    import wisc_pkg::*;
#(
    parameter int unsigned DRAIN_CYC = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rs,
    input  logic             id_rs_used,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_rt_used,
    input  logic             id_use_imm,
    input  logic             id_is_store,
    input  logic             id_is_load,
    input  logic [REG_W-1:0] id_rd,
    input  logic             id_wr_en,
    input  logic             ex_change_pc,
    input  logic             ex_exception,
    input  logic             ex_halt,
    output logic [1:0]       rs_select_ex,
    output logic [1:0]       rt_select_ex,
    output logic             stall_if,
    output logic             flush_ifid,
    output logic             bubble_ex,
    output logic             halted
);

    localparam int unsigned CNT_W = $clog2(DRAIN_CYC + 1);

    hz_state_e        state;
    hz_state_e        state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;

    // The WB slot is covered by register-file write-before-read, so only EX and MEM are tracked.
    sb_slot_t         ex_slot;
    logic             mem_v;
    logic [REG_W-1:0] mem_rd;

    logic             luse_c;
    logic             flush_req_c;
    logic [1:0]       rs_sel_c;
    logic [1:0]       rt_sel_c;

    assign luse_c = id_valid & ex_slot.v & ex_slot.ld &
                    ((id_rs_used & (id_rs == ex_slot.rd)) |
                     (id_rt_used & (id_rt == ex_slot.rd)));
    assign flush_req_c = ex_change_pc | ex_exception;

    wisc_fwd_sel u_rs_sel (
        .src      (id_rs),
        .used     (id_rs_used),
        .use_imm  (1'b0),
        .is_store (1'b0),
        .is_rt    (1'b0),
        .ex_v     (ex_slot.v),
        .ex_rd    (ex_slot.rd),
        .mem_v    (mem_v),
        .mem_rd   (mem_rd),
        .sel_c    (rs_sel_c)
    );

    wisc_fwd_sel u_rt_sel (
        .src      (id_rt),
        .used     (id_rt_used),
        .use_imm  (id_use_imm),
        .is_store (id_is_store),
        .is_rt    (1'b1),
        .ex_v     (ex_slot.v),
        .ex_rd    (ex_slot.rd),
        .mem_v    (mem_v),
        .mem_rd   (mem_rd),
        .sel_c    (rt_sel_c)
    );

    // State register for the halt sequencer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RUN;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next state plus pipeline control; flush outranks load-use.
    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        stall_if   = 1'b0;
        flush_ifid = 1'b0;
        bubble_ex  = 1'b0;
        case (state)
            RUN: begin
                if (flush_req_c) begin
                    flush_ifid = 1'b1;
                    bubble_ex  = 1'b1;
                end else if (luse_c) begin
                    stall_if  = 1'b1;
                    bubble_ex = 1'b1;
                end
                if (ex_halt) begin
                    state_nxt = DRAIN;
                    cnt_nxt   = CNT_W'(DRAIN_CYC);
                end
            end
            DRAIN: begin
                stall_if   = 1'b1;
                flush_ifid = 1'b1;
                bubble_ex  = 1'b1;
                cnt_nxt    = cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) begin
                    state_nxt = HALTED;
                end
            end
            HALTED: begin
                stall_if  = 1'b1;
                bubble_ex = 1'b1;
            end
            default: begin
                state_nxt = RUN;
            end
        endcase
    end

    // Scoreboard shift; downstream slots never freeze.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_slot <= '0;
            mem_v   <= 1'b0;
            mem_rd  <= '0;
        end else begin
            mem_v  <= ex_slot.v;
            mem_rd <= ex_slot.rd;
            if (bubble_ex) begin
                ex_slot <= '0;
            end else begin
                ex_slot.v  <= id_valid & id_wr_en;
                ex_slot.rd <= id_rd;
                ex_slot.ld <= id_is_load;
            end
        end
    end

    // Registered selects for EX and the sticky halted flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rs_select_ex <= RS_REG;
            rt_select_ex <= RT_REG;
            halted       <= 1'b0;
        end else begin
            rs_select_ex <= bubble_ex ? RS_REG : rs_sel_c;
            rt_select_ex <= bubble_ex ? RT_REG : rt_sel_c;
            halted       <= (state_nxt == HALTED);
        end
    end

endmodule

// File: tb/tb_wisc_hazard_ctrl.sv
// Randomized plus directed bench for wisc_hazard_ctrl against a queue-based pipeline model.
module tb_wisc_hazard_ctrl;

    localparam int DRAIN_CYC = 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       id_valid;
    logic [2:0] id_rs;
    logic       id_rs_used;
    logic [2:0] id_rt;
    logic       id_rt_used;
    logic       id_use_imm;
    logic       id_is_store;
    logic       id_is_load;
    logic [2:0] id_rd;
    logic       id_wr_en;
    logic       ex_change_pc;
    logic       ex_exception;
    logic       ex_halt;
    logic [1:0] rs_select_ex;
    logic [1:0] rt_select_ex;
    logic       stall_if;
    logic       flush_ifid;
    logic       bubble_ex;
    logic       halted;

    wisc_hazard_ctrl #(.DRAIN_CYC(DRAIN_CYC)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .id_valid     (id_valid),
        .id_rs        (id_rs),
        .id_rs_used   (id_rs_used),
        .id_rt        (id_rt),
        .id_rt_used   (id_rt_used),
        .id_use_imm   (id_use_imm),
        .id_is_store  (id_is_store),
        .id_is_load   (id_is_load),
        .id_rd        (id_rd),
        .id_wr_en     (id_wr_en),
        .ex_change_pc (ex_change_pc),
        .ex_exception (ex_exception),
        .ex_halt      (ex_halt),
        .rs_select_ex (rs_select_ex),
        .rt_select_ex (rt_select_ex),
        .stall_if     (stall_if),
        .flush_ifid   (flush_ifid),
        .bubble_ex    (bubble_ex),
        .halted       (halted)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: pipe[0] is the instruction in EX, pipe[1] in MEM, pipe[2] in WB.
    typedef struct {
        bit v;
        int rd;
        bit ld;
    } slot_t;

    slot_t pipe[$];
    int    halt_age;
    int    exp_rs;
    int    exp_rt;
    int    exp_halted;

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        slot_t empty;
        empty.v = 0; empty.rd = 0; empty.ld = 0;
        pipe.delete();
        for (int i = 0; i < 3; i++) pipe.push_back(empty);
        halt_age   = -1;
        exp_rs     = 0;
        exp_rt     = 2;
        exp_halted = 0;
    endtask

    function automatic int fwd(input int src, input bit used, input bit is_rt,
                               input bit imm_op, input bit store);
        if (is_rt && imm_op && !store) return 3;
        if (!used) return is_rt ? 2 : 0;
        if (pipe[0].v && pipe[0].rd == src) return is_rt ? 0 : 2;
        if (pipe[1].v && pipe[1].rd == src) return 1;
        return is_rt ? 2 : 0;
    endfunction

    task automatic set_instr(input bit v, input int rs, input bit rsu, input int rt, input bit rtu,
                             input bit imm, input bit st, input bit ld, input int rd, input bit wr);
        id_valid = v; id_rs = 3'(rs); id_rs_used = rsu; id_rt = 3'(rt); id_rt_used = rtu;
        id_use_imm = imm; id_is_store = st; id_is_load = ld; id_rd = 3'(rd); id_wr_en = wr;
        ex_change_pc = 0; ex_exception = 0; ex_halt = 0;
    endtask

    task automatic drive_random(input bit allow_halt);
        id_valid     = ($urandom_range(0, 7) != 0);
        id_rs        = 3'($urandom_range(0, 3));
        id_rt        = 3'($urandom_range(0, 3));
        id_rd        = 3'($urandom_range(0, 3));
        id_rs_used   = ($urandom_range(0, 3) != 0);
        id_rt_used   = ($urandom_range(0, 1) != 0);
        id_use_imm   = ($urandom_range(0, 2) == 0);
        id_is_load   = ($urandom_range(0, 3) == 0);
        id_is_store  = !id_is_load && ($urandom_range(0, 4) == 0);
        id_wr_en     = id_is_load || (!id_is_store && $urandom_range(0, 4) != 0);
        ex_change_pc = ($urandom_range(0, 9) == 0);
        ex_exception = ($urandom_range(0, 15) == 0);
        ex_halt      = allow_halt && ($urandom_range(0, 59) == 0);
    endtask

    // Called just after a falling edge with inputs already driven.
    task automatic cycle();
        bit    luse, flush_req, e_stall, e_flush, e_bubble;
        slot_t nxt;
        #1;
        luse = id_valid && pipe[0].v && pipe[0].ld &&
               ((id_rs_used && int'(id_rs) == pipe[0].rd) ||
                (id_rt_used && int'(id_rt) == pipe[0].rd));
        flush_req = ex_change_pc || ex_exception;
        e_stall = 0; e_flush = 0; e_bubble = 0;
        if (halt_age < 0) begin
            if (flush_req) begin
                e_flush = 1; e_bubble = 1;
            end else if (luse) begin
                e_stall = 1; e_bubble = 1;
            end
        end else if (halt_age <= DRAIN_CYC) begin
            e_stall = 1; e_flush = 1; e_bubble = 1;
        end else begin
            e_stall = 1; e_bubble = 1;
        end
        check("stall_if", int'(stall_if), int'(e_stall));
        check("flush_ifid", int'(flush_ifid), int'(e_flush));
        check("bubble_ex", int'(bubble_ex), int'(e_bubble));

        if (e_bubble) begin
            exp_rs = 0;
            exp_rt = 2;
        end else begin
            exp_rs = fwd(int'(id_rs), id_rs_used, 1'b0, 1'b0, 1'b0);
            exp_rt = fwd(int'(id_rt), id_rt_used, 1'b1, id_use_imm, id_is_store);
        end
        nxt.v  = !e_bubble && id_valid && id_wr_en;
        nxt.rd = e_bubble ? 0 : int'(id_rd);
        nxt.ld = !e_bubble && id_is_load;
        pipe.push_front(nxt);
        void'(pipe.pop_back());
        if (halt_age < 0) begin
            if (ex_halt) halt_age = 1;
        end else if (halt_age < 100) begin
            halt_age++;
        end
        exp_halted = (halt_age > DRAIN_CYC) ? 1 : 0;

        @(posedge clk);
        #1;
        check("rs_select_ex", int'(rs_select_ex), exp_rs);
        check("rt_select_ex", int'(rt_select_ex), exp_rt);
        check("halted", int'(halted), exp_halted);
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        set_instr(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        set_instr(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        model_reset();
        #12;
        check("rst_rs_sel", int'(rs_select_ex), 0);
        check("rst_rt_sel", int'(rt_select_ex), 2);
        check("rst_halted", int'(halted), 0);
        check("rst_stall", int'(stall_if), 0);
        check("rst_flush", int'(flush_ifid), 0);
        check("rst_bubble", int'(bubble_ex), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Back-to-back ALU, one gap, two gaps.
        set_instr(1, 5, 1, 6, 1, 0, 0, 0, 1, 1); cycle();
        set_instr(1, 1, 1, 3, 1, 0, 0, 0, 2, 1); cycle();
        set_instr(1, 7, 1, 6, 1, 0, 0, 0, 1, 1); cycle();
        set_instr(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); cycle();
        set_instr(1, 1, 1, 3, 1, 0, 0, 0, 2, 1); cycle();
        set_instr(1, 7, 1, 6, 1, 0, 0, 0, 1, 1); cycle();
        set_instr(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); cycle(); cycle();
        set_instr(1, 1, 1, 3, 1, 0, 0, 0, 2, 1); cycle();
        // Load-use, then load followed by an independent instruction.
        set_instr(1, 0, 1, 0, 0, 1, 0, 1, 4, 1); cycle();
        set_instr(1, 4, 1, 6, 1, 0, 0, 0, 5, 1); cycle(); cycle();
        set_instr(1, 0, 1, 0, 0, 1, 0, 1, 4, 1); cycle();
        set_instr(1, 3, 1, 6, 1, 0, 0, 0, 5, 1); cycle();
        // Store data forwarding and immediate operand.
        set_instr(1, 5, 1, 6, 1, 0, 0, 0, 2, 1); cycle();
        set_instr(1, 1, 1, 2, 1, 1, 1, 0, 0, 0); cycle();
        set_instr(1, 3, 1, 0, 0, 1, 0, 0, 2, 1); cycle();
        // Flush while load-use is pending.
        set_instr(1, 0, 1, 0, 0, 1, 0, 1, 4, 1); cycle();
        set_instr(1, 4, 1, 6, 1, 0, 0, 0, 5, 1); ex_change_pc = 1; cycle();
        set_instr(1, 4, 1, 6, 1, 0, 0, 0, 5, 1); cycle();
        // Halt, then attempts to disturb the halted state.
        set_instr(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); ex_halt = 1; cycle();
        ex_halt = 0;
        for (int i = 0; i < 6; i++) begin
            set_instr(1, 1, 1, 2, 1, 0, 0, 0, 3, 1);
            ex_halt = (i % 2 == 0); ex_change_pc = (i % 3 == 0);
            cycle();
        end
        // Async reset mid-drain, between clock edges.
        set_instr(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        do_reset();
        set_instr(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); ex_halt = 1; cycle();
        set_instr(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); cycle();
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check("async_halted", int'(halted), 0);
        check("async_rs_sel", int'(rs_select_ex), 0);
        check("async_rt_sel", int'(rt_select_ex), 2);
        check("async_stall", int'(stall_if), 0);
        @(negedge clk);
        rst_n = 1'b1;
        set_instr(1, 5, 1, 6, 1, 0, 0, 0, 1, 1); cycle();
        set_instr(1, 1, 1, 3, 1, 0, 0, 0, 2, 1); cycle();

        // Randomized episodes, each closed by a reset.
        for (int ep = 0; ep < 6; ep++) begin
            do_reset();
            for (int c = 0; c < 300; c++) begin
                drive_random(ep >= 2);
                cycle();
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
